// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED frame scheduler.
// Holds the FSM state encoding, the source ids and the frame-period helper.
package led_sched_pkg;

    localparam int MATRIX_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        WAIT_START,
        WAIT_DONE
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Clock cycles per refresh; the integer division truncates toward zero.
    function automatic int tick_period(input int clk_freq, input int frame_hz);
        return clk_freq / frame_hz;
    endfunction

endpackage

// File: rtl/led_frame_scheduler_tick_gen.sv
// Free-running refresh timer: counts 0..TICK_PERIOD-1 forever and flags the
// last count as a one-cycle frame tick. TICK_PERIOD must be at least 4.
module frame_tick_gen
    import led_sched_pkg::*;
#(
    parameter int CLK_FREQ = 20000000,
    parameter int FRAME_HZ = 30
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int TICK_PERIOD = tick_period(CLK_FREQ, FRAME_HZ);
    localparam int TW          = $clog2(TICK_PERIOD);
    localparam logic [TW-1:0] LAST_COUNT = TW'(TICK_PERIOD - 1);

    logic [TW-1:0] count;

    // NOTE: clocked state is always written with <= so every register samples
    // the pre-edge values of its neighbours, whatever order the blocks run in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST_COUNT);

endmodule

// File: rtl/led_frame_scheduler.sv
// Shares one ws2812 strip driver between two 16x16 matrix producers, starting
// one frame per refresh tick with round-robin arbitration between sources.
module led_frame_scheduler
    import led_sched_pkg::*;
#(
    parameter int CLK_FREQ = 20000000,
    parameter int FRAME_HZ = 30,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                req_a,
    input  logic [MATRIX_W-1:0] matrix_a,
    output logic                ack_a,
    input  logic                req_b,
    input  logic [MATRIX_W-1:0] matrix_b,
    output logic                ack_b,
    input  logic                drv_busy,
    output logic                drv_update,
    output logic [MATRIX_W-1:0] drv_matrix,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                overrun,
    input  logic                clr_overrun
);

    state_t state;
    state_t state_next;

    logic tick;
    logic grant_valid;
    logic grant_src;
    logic last_grant;
    logic frame_done;
    logic overrun_set;

    frame_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .FRAME_HZ (FRAME_HZ)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Round robin: on a tie the source that did not win last time is granted.
    always_comb begin
        grant_valid = req_a | req_b;
        if (req_a && req_b) begin
            grant_src = ~last_grant;
        end else if (req_a) begin
            grant_src = SRC_A;
        end else begin
            grant_src = SRC_B;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output is given a default before the case so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (tick && enable) state_next = SELECT;
            SELECT:     state_next = LAUNCH;
            LAUNCH:     if (!drv_busy) state_next = WAIT_START;
            WAIT_START: if (drv_busy) state_next = WAIT_DONE;
            WAIT_DONE:  if (!drv_busy) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_a      = 1'b0;
        ack_b      = 1'b0;
        drv_update = 1'b0;
        frame_done = 1'b0;
        case (state)
            SELECT: begin
                ack_a = grant_valid && (grant_src == SRC_A);
                ack_b = grant_valid && (grant_src == SRC_B);
            end
            LAUNCH:    drv_update = !drv_busy;
            WAIT_DONE: frame_done = !drv_busy;
            default: ;
        endcase
    end

    assign overrun_set = tick && (state != IDLE);

    // NOTE: drv_matrix is an ordinary register bank, not a memory, so it is
    // reset; a blank frame is what the driver must see before the first grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drv_matrix <= '0;
            last_grant <= SRC_B;
        end else if (ack_a || ack_b) begin
            drv_matrix <= ack_a ? matrix_a : matrix_b;
            last_grant <= grant_src;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // A dropped tick outranks a simultaneous clear so the overrun is not lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with a 100-cycle frame period and a
// simple strip-driver model whose busy length is set per scenario.
module tb_led_frame_scheduler;
    import led_sched_pkg::*;

    localparam logic [255:0] PAT_A = {16{16'hF0F0}};
    localparam logic [255:0] PAT_B = {16{16'h0FF0}};

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         req_a = 1'b0;
    logic         req_b = 1'b0;
    logic         clr_overrun = 1'b0;
    logic [255:0] matrix_a = '0;
    logic [255:0] matrix_b = '0;
    logic         ack_a;
    logic         ack_b;
    logic         drv_busy;
    logic         drv_update;
    logic [255:0] drv_matrix;
    logic [15:0]  frame_cnt;
    logic         overrun;

    int cyc;
    int busy_len = 40;
    int busy_cnt;
    int checks = 0;
    int errors = 0;
    int upd_total = 0;
    int ack_total = 0;
    int excl_viol = 0;

    led_frame_scheduler #(
        .CLK_FREQ (1000),
        .FRAME_HZ (10),
        .CNT_W    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .req_a       (req_a),
        .matrix_a    (matrix_a),
        .ack_a       (ack_a),
        .req_b       (req_b),
        .matrix_b    (matrix_b),
        .ack_b       (ack_b),
        .drv_busy    (drv_busy),
        .drv_update  (drv_update),
        .drv_matrix  (drv_matrix),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clock = ~clock;

    // Cycle number since reset release; cycle 0 is the one in which reset falls.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Driver model: busy from the cycle after update, for busy_len cycles.
    always @(posedge clock or posedge reset) begin
        if (reset)               busy_cnt <= 0;
        else if (drv_update)     busy_cnt <= busy_len;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end
    assign drv_busy = (busy_cnt != 0);

    always @(negedge clock) begin
        if (!reset) begin
            if (drv_update)    upd_total <= upd_total + 1;
            if (ack_a || ack_b) ack_total <= ack_total + 1;
            if (32'(ack_a) + 32'(ack_b) + 32'(drv_update) > 1) excl_viol <= excl_viol + 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive_at(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic sample_at(input int n);
        do @(negedge clock); while (cyc < n);
    endtask

    task automatic wait_ack(input int budget, output int src, output int at);
        src = -1;
        at  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (ack_a || ack_b) begin
                src = ack_a ? 0 : 1;
                at  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_update(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (drv_update) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_cnt(input int target, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (frame_cnt == 16'(target)) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int src;
        int at;
        int upd_base;
        int ack_base;

        // Single source A, reset values first.
        busy_len = 40;
        enable   = 1'b1;
        matrix_a = PAT_A;
        req_a    = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_ack_a", 256'(ack_a), 256'd0);
        check("rst_ack_b", 256'(ack_b), 256'd0);
        check("rst_update", 256'(drv_update), 256'd0);
        check("rst_matrix", drv_matrix, 256'd0);
        check("rst_cnt", 256'(frame_cnt), 256'd0);
        check("rst_overrun", 256'(overrun), 256'd0);
        @(negedge clock);
        reset = 1'b0;
        wait_ack(200, src, at);
        check("a_only_src", 256'(src), 256'd0);
        check("a_only_ack_cyc", 256'(at), 256'd100);
        @(posedge clock);
        #1;
        req_a = 1'b0;
        wait_update(20, at);
        check("a_only_upd_cyc", 256'(at), 256'd101);
        check("a_only_matrix", drv_matrix, PAT_A);
        wait_cnt(1, 100, at);
        check("a_only_done_cyc", 256'(at), 256'd143);

        // Both sources held: A,B,A,B.
        matrix_b = PAT_B;
        req_a    = 1'b1;
        req_b    = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_ack(150, src, at);
            check($sformatf("rr_src%0d", k), 256'(src), 256'(k % 2));
            check($sformatf("rr_cyc%0d", k), 256'(at), 256'(100 * (k + 1)));
            wait_update(20, at);
            check($sformatf("rr_matrix%0d", k), drv_matrix, (k % 2 == 1) ? PAT_B : PAT_A);
        end
        wait_cnt(4, 200, at);
        check("rr_cnt4_cyc", 256'(at), 256'd443);
        check("rr_overrun", 256'(overrun), 256'd0);
        drive_at(cyc + 1);
        req_a = 1'b0;
        req_b = 1'b0;

        // No requests: blank frame re-sent every tick.
        do_reset();
        upd_base = upd_total;
        ack_base = ack_total;
        wait_update(200, at);
        check("idle_upd_cyc", 256'(at), 256'd101);
        check("idle_matrix", drv_matrix, 256'd0);
        sample_at(243);
        check("idle_cnt", 256'(frame_cnt), 256'd2);
        check("idle_upds", 256'(upd_total - upd_base), 256'd2);
        check("idle_acks", 256'(ack_total - ack_base), 256'd0);

        // Slow driver: overrun and clear priority.
        busy_len = 150;
        do_reset();
        sample_at(199);
        check("ovr_before", 256'(overrun), 256'd0);
        sample_at(200);
        check("ovr_set", 256'(overrun), 256'd1);
        sample_at(452);
        check("ovr_cnt_452", 256'(frame_cnt), 256'd1);
        sample_at(453);
        check("ovr_cnt_453", 256'(frame_cnt), 256'd2);
        drive_at(460);
        clr_overrun = 1'b1;
        drive_at(461);
        clr_overrun = 1'b0;
        sample_at(461);
        check("ovr_cleared", 256'(overrun), 256'd0);
        sample_at(598);
        check("ovr_idle_tick", 256'(overrun), 256'd0);
        drive_at(599);
        clr_overrun = 1'b1;
        drive_at(600);
        clr_overrun = 1'b0;
        sample_at(600);
        check("ovr_set_wins", 256'(overrun), 256'd1);

        // Enable dropped during WAIT_DONE.
        busy_len = 40;
        do_reset();
        upd_base = upd_total;
        drive_at(120);
        enable = 1'b0;
        sample_at(143);
        check("en_cnt", 256'(frame_cnt), 256'd1);
        sample_at(390);
        check("en_upds", 256'(upd_total - upd_base), 256'd1);
        check("en_cnt_hold", 256'(frame_cnt), 256'd1);
        check("en_overrun", 256'(overrun), 256'd0);
        drive_at(391);
        enable = 1'b1;
        wait_update(100, at);
        check("en_resume_cyc", 256'(at), 256'd401);

        // Reset in WAIT_DONE of the second frame.
        matrix_a = PAT_A;
        req_a    = 1'b1;
        do_reset();
        drive_at(220);
        check("mid_state", 256'(dut.state), 256'(WAIT_DONE));
        check("mid_cnt", 256'(frame_cnt), 256'd1);
        check("mid_matrix", drv_matrix, PAT_A);
        reset = 1'b1;
        #1;
        check("mid_rst_state", 256'(dut.state), 256'(IDLE));
        check("mid_rst_matrix", drv_matrix, 256'd0);
        check("mid_rst_cnt", 256'(frame_cnt), 256'd0);
        check("mid_rst_ack", 256'(ack_a), 256'd0);
        check("mid_rst_update", 256'(drv_update), 256'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_ack(200, src, at);
        check("mid_rel_src", 256'(src), 256'd0);
        check("mid_rel_cyc", 256'(at), 256'd100);
        @(posedge clock);
        #1;
        req_a = 1'b0;
        repeat (2) @(negedge clock);

        check("exclusive", 256'(excl_viol), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences the ws2812 strip driver and shares it between two 16x16 matrix producers: source A (game renderer) and source B (IMU tilt display).
- A free-running frame timer paces refreshes at FRAME_HZ.
- On each tick, a round-robin arbiter grants one pending source and latches its 256-bit matrix. The block pulses the driver's update, tracks completion through the driver's busy, and reports frame count and overruns.

Parameters:
- CLK_FREQ, 20000000: system clock in Hz.
- FRAME_HZ, 30: refresh rate. TICK_PERIOD = CLK_FREQ/FRAME_HZ, integer division, must be >= 4.
- CNT_W, 16: width of frame_cnt.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  when low, no new frame starts; any frame in flight completes.
- req_a  in  1  source A has a frame pending; level, held until ack_a.
- matrix_a  in  256  source A frame, bit r*16+c = pixel on; sampled on ack_a cycle.
- ack_a  out  1  one-cycle grant pulse to A.
- req_b  in  1  as req_a, for source B.
- matrix_b  in  256  as matrix_a, for source B.
- ack_b  out  1  as ack_a, for source B.
- drv_busy  in  1  driver busy (high from the cycle after update until latch ends).
- drv_update  out  1  one-cycle start pulse to driver.
- drv_matrix  out  256  registered frame presented to driver; stable from update until busy falls.
- frame_cnt  out  CNT_W  completed frames, wraps to 0 after all-ones.
- overrun  out  1  sticky: a tick arrived while not IDLE.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset values:
  - all outputs 0, including drv_matrix (blank frame) and frame_cnt
  - state IDLE, tick counter 0
  - last_grant = B, so A wins the first tie.
- Tick generator:
  - counter runs 0..TICK_PERIOD-1 regardless of state or enable.
  - tick is asserted for one cycle when the counter is at TICK_PERIOD-1.
- States:
  - IDLE: on tick && enable, go to SELECT. On tick && !enable, do nothing.
  - SELECT (1 cycle): grant and load drv_matrix; go to LAUNCH.
    - both requesting: grant the source not equal to last_grant.
    - only one requesting: grant that source.
    - granted source: assert its ack for one cycle, load drv_matrix from its matrix, update last_grant.
    - no requests: no ack, drv_matrix and last_grant unchanged; the held frame is re-sent.
  - LAUNCH: if !drv_busy, assert drv_update for one cycle and go to WAIT_START; otherwise stay in LAUNCH.
  - WAIT_START: on drv_busy high, go to WAIT_DONE.
  - WAIT_DONE: on drv_busy low, increment frame_cnt and go to IDLE.
- Latency: tick in IDLE at cycle T gives ack at T+1 and drv_update at T+2 if the driver is idle.
- Overrun:
  - a tick in any state other than IDLE sets overrun; that tick is dropped, not queued.
  - clr_overrun clears overrun; if a set and a clear occur in the same cycle, set wins.
- At most one of ack_a, ack_b and drv_update is high in any cycle. drv_update never coincides with an ack.
- A req dropped before its ack is simply not granted; there is no error.
- enable falling mid-frame: the sequence completes normally, then the block stays in IDLE.
- Reset asserted mid-frame: the FSM returns to IDLE immediately. The driver has its own reset and is reset alongside.

Decomposition:
- Package led_sched_pkg holds:
  - state enum {IDLE, SELECT, LAUNCH, WAIT_START, WAIT_DONE}
  - source encoding constants SRC_A=0, SRC_B=1
  - localparam function for TICK_PERIOD
- Sub-module frame_tick_gen (parameters CLK_FREQ and FRAME_HZ; ports clock, reset, tick) holds the period counter.
- The arbiter and FSM stay in the top.

Test Plan:
- Bench parameters: CLK_FREQ=1000, FRAME_HZ=10 (TICK_PERIOD=100). Driver model raises busy 1 cycle after update and holds it for 40 cycles.
- Only req_a high, matrix_a=pattern 0x...F0F0:
  - ack_a at cycle 100, drv_update at cycle 101, drv_matrix=pattern, frame_cnt=1 after busy falls.
- req_a and req_b held high for 4 ticks:
  - acks alternate A,B,A,B, and frame_cnt=4.
- No requests, enable=1:
  - each tick re-sends a zero frame with no acks; frame_cnt increments every 100 cycles.
- Driver model busy 150 cycles:
  - the second tick sets overrun; frame_cnt advances once per 200 cycles.
  - clr_overrun clears overrun; clear and tick in the same cycle leaves overrun=1.
- enable low during WAIT_DONE:
  - the frame completes and frame_cnt increments; there is no further drv_update until enable returns high.
- Reset asserted in WAIT_DONE:
  - all outputs are 0 asynchronously and the FSM is in IDLE.
  - after release, the first ack is at the first tick, 100 cycles later.
